// File: rtl/keypad_emulator_pkg.sv
// Purpose : shared keypad definitions (state encoding, key map) for emulator and scanner.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } kp_state_e;

    // Hex key code -> {row[1:0], col[1:0]}. The scanner decodes with the same
    // table, so the two sides cannot disagree on the physical layout.
    function automatic logic [3:0] key2rc(input logic [3:0] code);
        logic [3:0] rc;
        rc = 4'b0000;
        case (code)
            4'h1: rc = 4'b00_00;
            4'h2: rc = 4'b00_01;
            4'h3: rc = 4'b00_10;
            4'hA: rc = 4'b00_11;
            4'h4: rc = 4'b01_00;
            4'h5: rc = 4'b01_01;
            4'h6: rc = 4'b01_10;
            4'hB: rc = 4'b01_11;
            4'h7: rc = 4'b10_00;
            4'h8: rc = 4'b10_01;
            4'h9: rc = 4'b10_10;
            4'hC: rc = 4'b10_11;
            4'hE: rc = 4'b11_00;
            4'h0: rc = 4'b11_01;
            4'hF: rc = 4'b11_10;
            4'hD: rc = 4'b11_11;
            default: rc = 4'b00_00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Purpose : press-request handshake plus scanner col/row lines of the keypad emulator.
// Latency : n/a (signal bundle only).
// Backpr. : key_valid/key_ready handshake; col/row carry no flow control.
// Ports   : key_valid, key_code[3:0], hold_len[15:0], col[3:0] driven by master;
//           key_ready, row[3:0], contact, done driven by the emulator (slave).
interface keypad_emulator_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] hold_len;
    logic        key_ready;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        contact;
    logic        done;

    modport master (
        output key_valid, key_code, hold_len, col,
        input  key_ready, row, contact, done
    );

    modport slave (
        input  key_valid, key_code, hold_len, col,
        output key_ready, row, contact, done
    );
endinterface

// File: rtl/keypad_emulator_bounce_gen.sv
// Purpose : shared state-duration down-counter and bounce-phase generator producing contact.
// Latency : contact follows the registered state/phase, no extra delay.
// Backpr. : none; counters run freely and are reloaded on every state entry.
// Ports   : clk, reset (sync, active-low), load_i/load_val_i (reload on entry),
//           state_i (current state), cnt_zero_o (last cycle of state), contact_o.
module bounce_gen
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  kp_state_e   state_i,
    output logic        cnt_zero_o,
    output logic        contact_o
);

    localparam int PW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PH_RELOAD = PW'(BOUNCE_CYCLES - 1);

    logic [15:0]   cnt_q;
    logic [PW-1:0] ph_cnt_q;
    logic          phase_q;   // 0 = first half-period of a bounce pair

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= 16'd0;
            ph_cnt_q <= '0;
            phase_q  <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= load_val_i;
            ph_cnt_q <= PH_RELOAD;
            phase_q  <= 1'b0;
        end else begin
            if (cnt_q != 16'd0) begin
                cnt_q <= cnt_q - 16'd1;
            end
            if (ph_cnt_q == '0) begin
                ph_cnt_q <= PH_RELOAD;
                phase_q  <= ~phase_q;
            end else begin
                ph_cnt_q <= ph_cnt_q - 1'b1;
            end
        end
    end

    assign cnt_zero_o = (cnt_q == 16'd0);

    // Press bounce starts closed, release bounce starts open.
    assign contact_o = (state_i == ST_HOLD) ||
                       ((state_i == ST_BOUNCE_IN)  && !phase_q) ||
                       ((state_i == ST_BOUNCE_OUT) &&  phase_q);

endmodule

// File: rtl/keypad_emulator.sv
// Purpose : 4x4 matrix keypad responder: presses one key with programmable bounce.
// Latency : accept -> contact next cycle; col -> row combinational (zero cycles).
// Backpr. : key_ready only in IDLE; key_valid ignored while busy, no queueing.
// Ports   : clk, reset (sync, active-low), kif (slave): key_valid/key_code/hold_len/
//           key_ready handshake, col in, row/contact/done out.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES  = 8,
    parameter int BOUNCE_TOGGLES = 3,
    parameter int GAP_CYCLES     = 16
) (
    input  logic            clk,
    input  logic            reset,
    keypad_emulator_if.slave kif
);

    localparam logic        BOUNCE_EN   = (BOUNCE_TOGGLES != 0);
    localparam int          BOUNCE_LEN  = 2 * BOUNCE_TOGGLES * BOUNCE_CYCLES;
    localparam logic [15:0] BOUNCE_LOAD = 16'((BOUNCE_LEN > 0) ? BOUNCE_LEN - 1 : 0);
    localparam logic [15:0] GAP_LOAD    = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    kp_state_e   state_q, state_d;
    logic [1:0]  kcol_q, krow_q;
    logic [15:0] hold_q;
    logic        key_ready_q;
    logic        done_q;

    logic        accept;
    logic        cnt_zero;
    logic        contact;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] hold_eff;

    assign accept = kif.key_valid && key_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (accept)   state_d = BOUNCE_EN ? ST_BOUNCE_IN : ST_HOLD;
            ST_BOUNCE_IN:  if (cnt_zero) state_d = ST_HOLD;
            ST_HOLD:       if (cnt_zero) state_d = BOUNCE_EN ? ST_BOUNCE_OUT : ST_GAP;
            ST_BOUNCE_OUT: if (cnt_zero) state_d = ST_GAP;
            ST_GAP:        if (cnt_zero) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Without bounce HOLD is entered straight from IDLE, before hold_len has
    // been registered, so the live input is used for that reload.
    assign hold_eff = (state_q == ST_IDLE) ? kif.hold_len : hold_q;

    // Counter holds "cycles remaining minus one"; zero marks the last cycle.
    always_comb begin
        load_val = 16'd0;
        case (state_d)
            ST_BOUNCE_IN,
            ST_BOUNCE_OUT: load_val = BOUNCE_LOAD;
            ST_HOLD:       load_val = (hold_eff == 16'd0) ? 16'd0 : hold_eff - 16'd1;
            ST_GAP:        load_val = GAP_LOAD;
            default:       load_val = 16'd0;
        endcase
    end

    assign load = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b1;
            done_q      <= 1'b0;
            kcol_q      <= 2'd0;
            krow_q      <= 2'd0;
            hold_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            key_ready_q <= (state_d == ST_IDLE);
            done_q      <= (state_q == ST_GAP) && (state_d == ST_IDLE);
            if (accept) begin
                {krow_q, kcol_q} <= key2rc(kif.key_code);
                hold_q           <= kif.hold_len;
            end
        end
    end

    bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES)
    ) u_bounce_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .state_i    (state_q),
        .cnt_zero_o (cnt_zero),
        .contact_o  (contact)
    );

    // Only the pressed key's row can answer, and only to its own column bit.
    assign kif.row       = (contact && kif.col[kcol_q]) ? (4'b0001 << krow_q) : 4'b0000;
    assign kif.contact   = contact;
    assign kif.key_ready = key_ready_q;
    assign kif.done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Purpose : self-checking bench for keypad_emulator (no-bounce and default-bounce instances).
// Latency : expected per-cycle contact/ready/done queued at accept, row derived from live col.
// Backpr. : exercises key_valid held high across a busy press.
module tb_keypad_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    keypad_emulator_if if0 ();
    keypad_emulator_if if1 ();

    keypad_emulator #(
        .BOUNCE_CYCLES  (8),
        .BOUNCE_TOGGLES (0),
        .GAP_CYCLES     (16)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .kif   (if0)
    );

    keypad_emulator dut1 (
        .clk   (clk),
        .reset (reset),
        .kif   (if1)
    );

    typedef struct {
        logic contact;
        logic ready;
        logic done;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] keymap [16];
    logic [3:0] sweep_tab [7];
    logic [1:0] exp_kr, exp_kc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic drive_all(input logic [3:0] code, input logic [15:0] hold, input logic [3:0] c);
        if0.key_code = code;  if1.key_code = code;
        if0.hold_len = hold;  if1.hold_len = hold;
        if0.col      = c;     if1.col      = c;
    endtask

    task automatic set_col(input logic [3:0] c);
        if0.col = c;
        if1.col = c;
    endtask

    task automatic set_kv(input int w, input logic v);
        if (w == 1) if1.key_valid = v;
        else        if0.key_valid = v;
    endtask

    function automatic logic [3:0] obs_row(input int w);
        return (w == 1) ? if1.row : if0.row;
    endfunction
    function automatic logic obs_contact(input int w);
        return (w == 1) ? if1.contact : if0.contact;
    endfunction
    function automatic logic obs_ready(input int w);
        return (w == 1) ? if1.key_ready : if0.key_ready;
    endfunction
    function automatic logic obs_done(input int w);
        return (w == 1) ? if1.done : if0.done;
    endfunction

    task automatic push_n(input int n, input logic c);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.contact = c;
            e.ready   = 1'b0;
            e.done    = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_idle(input int w, input string tag);
        check({tag, "_row"},     {28'd0, obs_row(w)},   32'd0);
        check({tag, "_contact"}, {31'd0, obs_contact(w)}, 32'd0);
        check({tag, "_ready"},   {31'd0, obs_ready(w)}, 32'd1);
        check({tag, "_done"},    {31'd0, obs_done(w)},  32'd0);
    endtask

    // Called at a falling edge; presses one key on instance w and scores
    // every cycle up to and including the done cycle (or 'limit' cycles).
    task automatic do_press(input int w, input logic [3:0] code, input logic [15:0] hold,
                            input logic [3:0] colv, input bit sweep, input bit keep,
                            input logic [3:0] next_code, input int limit);
        int         tog;
        int         hcyc;
        int         n;
        exp_t       e;
        logic [3:0] exp_row;
        logic [3:0] cur_col;
        tog  = (w == 1) ? 3 : 0;
        hcyc = (hold == 16'd0) ? 1 : int'(hold);
        for (int p = 0; p < 16; p++) begin
            if (keymap[p] == code) begin
                exp_kr = 2'(p / 4);
                exp_kc = 2'(p % 4);
            end
        end
        drive_all(code, hold, colv);
        set_kv(w, 1'b1);
        #1;
        check("ready_pre", {31'd0, obs_ready(w)}, 32'd1);
        @(negedge clk);
        if (keep) begin
            if0.key_code = next_code;
            if1.key_code = next_code;
        end else begin
            set_kv(w, 1'b0);
        end
        for (int t = 0; t < tog; t++) begin
            push_n(8, 1'b1);
            push_n(8, 1'b0);
        end
        push_n(hcyc, 1'b1);
        for (int t = 0; t < tog; t++) begin
            push_n(8, 1'b0);
            push_n(8, 1'b1);
        end
        push_n(16, 1'b0);
        e.contact = 1'b0;
        e.ready   = 1'b1;
        e.done    = 1'b1;
        exp_q.push_back(e);
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            if (sweep) set_col(sweep_tab[n % 7]);
            #1;
            e       = exp_q.pop_front();
            cur_col = (w == 1) ? if1.col : if0.col;
            exp_row = (e.contact && cur_col[exp_kc]) ? (4'b0001 << exp_kr) : 4'b0000;
            check("contact", {31'd0, obs_contact(w)}, {31'd0, e.contact});
            check("row",     {28'd0, obs_row(w)},     {28'd0, exp_row});
            check("ready",   {31'd0, obs_ready(w)},   {31'd0, e.ready});
            check("done",    {31'd0, obs_done(w)},    {31'd0, e.done});
            n++;
            if (exp_q.size() > 0 && n < limit) @(negedge clk);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'hE, 4'h0, 4'hF, 4'hD};
        sweep_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1111, 4'b1010};

        // Reset with every column driven.
        reset         = 1'b0;
        if0.key_valid = 1'b0;
        if1.key_valid = 1'b0;
        drive_all(4'h0, 16'd0, 4'b1111);
        repeat (3) @(negedge clk);
        #1;
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        reset = 1'b1;
        @(negedge clk);

        // No bounce: key 5, 10 closed cycles, done 27 cycles after accept.
        do_press(0, 4'h5, 16'd10, 4'b0010, 1'b0, 1'b0, 4'h0, 1000);

        // Full key map with a column sweep during HOLD.
        for (int k = 0; k < 16; k++) begin
            do_press(0, 4'(k), 16'd8, 4'b0001, 1'b1, 1'b0, 4'h0, 1000);
        end

        // Default bounce, key 1, hold 20: 132 busy cycles.
        do_press(1, 4'h1, 16'd20, 4'b0001, 1'b0, 1'b0, 4'h0, 1000);

        // key_valid held: code switches to A while busy, A taken on done cycle.
        do_press(1, 4'h6, 16'd5, 4'b0100, 1'b0, 1'b1, 4'hA, 1000);
        do_press(1, 4'hA, 16'd5, 4'b1000, 1'b0, 1'b0, 4'h0, 1000);

        // Abort in HOLD (6th held cycle), then reset.
        do_press(1, 4'h7, 16'd40, 4'b0001, 1'b0, 1'b0, 4'h0, 48 + 6);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_idle(1, "abort");
        reset = 1'b1;
        @(negedge clk);

        // hold_len = 0 behaves as a single held cycle.
        do_press(0, 4'h9, 16'd0, 4'b0100, 1'b0, 1'b0, 4'h0, 1000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable model of the 4x4 matrix keypad, i.e. the responder side of the scanner interface that `keypadhandler` drives. The scanner drives one-hot columns; this block returns the row lines of a single "pressed" key, with programmable contact bounce on press and release. It is used in hardware-in-the-loop builds and in the scanner bench, where it replaces hand-wired row/column switching.

## Interface
Parameters:
- `BOUNCE_CYCLES`, 8: clock cycles per bounce half-period.
- `BOUNCE_TOGGLES`, 3: closed/open pairs in each bounce burst; 0 disables bounce.
- `GAP_CYCLES`, 16: forced-open cycles after release, before the next key is accepted.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-low.
- `key_valid`  in  1  press request.
- `key_code`  in  4  hex key to press (0x0-0xF).
- `hold_len`  in  16  closed cycles in HOLD, sampled on accept; 0 is treated as 1.
- `key_ready`  out  1  high only in IDLE.
- `col`  in  4  scanner column drive, one-hot, active-high.
- `row`  out  4  row response, active-high.
- `contact`  out  1  current switch state (1 = closed).
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- Key map (row,col): 1(0,0) 2(0,1) 3(0,2) A(0,3); 4(1,0) 5(1,1) 6(1,2) B(1,3); 7(2,0) 8(2,1) 9(2,2) C(2,3); E(3,0) 0(3,1) F(3,2) D(3,3).
- `row` is combinational: `row = contact && col[kcol] ? onehot(krow) : 4'b0`. `kcol`/`krow` are registered from `key_code` on accept. No other row is ever asserted; `col` bits other than `kcol` are ignored.
- Handshake: a transfer occurs when `key_valid && key_ready` at a rising edge. `key_code` and `hold_len` are captured. `key_valid` is ignored while busy; there is no queueing.
- FSM `IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE`:
  - IDLE: `contact=0`, `key_ready=1`.
  - BOUNCE_IN: 2·BOUNCE_TOGGLES·BOUNCE_CYCLES cycles. `contact` alternates every BOUNCE_CYCLES, starting closed.
  - HOLD: `hold_len` cycles, `contact=1`.
  - BOUNCE_OUT: same length as BOUNCE_IN, starting open.
  - GAP: GAP_CYCLES cycles, `contact=0`. On the last cycle the FSM goes to IDLE and `done=1` for the first IDLE cycle.
- If BOUNCE_TOGGLES=0, both bounce states are skipped (BOUNCE_IN->HOLD, HOLD->GAP directly).
- One 16-bit down-counter is shared by all timed states and reloaded on every state entry. A second counter tracks the bounce phase.

## Timing
- Reset (`reset=0` at an edge): state IDLE, `contact=0`, `row=0`, `done=0`, `key_ready=1`, counters 0, `kcol`/`krow`=0. Reset mid-press aborts immediately; `row` is 0 from the cycle after that edge.
- Accept at edge k: `key_ready=0` from k+1. `contact=1` from k+1 (first bounce-closed cycle, or HOLD if no bounce).
- Total busy time, accept to `key_ready=1`: 4·BOUNCE_TOGGLES·BOUNCE_CYCLES + max(hold_len,1) + GAP_CYCLES cycles.
- A `key_valid` held high continuously is accepted again on the `done` cycle, since `key_ready=1` then.
- `col` to `row` latency is zero. A `col` change during HOLD is reflected the same cycle.
- `col=0` or multi-hot: `row` responds only to bit `kcol`.

## Structure
- Package `keypad_pkg`:
  - `typedef enum logic [2:0]` for emulator states.
  - function `key2rc(logic [3:0]) -> {row[1:0], col[1:0]}` holding the map above.
  - `ROWS=4`, `COLS=4`.
- The scanner (`keypadhandler`) imports the same map, so encoder and decoder cannot diverge.
- One sub-module, `bounce_gen`: the counters plus the alternating-phase logic, producing `contact`. The top module holds the FSM, the handshake and the row mux.

## Test plan
- Reset: hold `reset=0` 3 cycles with `col=4'b1111` -> `row=0`, `contact=0`, `key_ready=1`, `done=0`.
- No bounce: BOUNCE_TOGGLES=0, key 0x5, hold_len=10, `col=4'b0010` -> `row=4'b0010` for exactly 10 cycles starting k+1; `done` at k+1+10+16.
- Full map: BOUNCE_TOGGLES=0, scan all 16 codes while sweeping `col` -> `row` nonzero only at the mapped column and equal to onehot(row). Check: 0x0 gives `col=4'b0010`->`row=4'b1000`; 0xD gives `col=4'b1000`->`row=4'b1000`.
- Bounce: defaults, key 0x1, hold_len=20, `col=4'b0001` -> `contact` pattern 8 closed / 8 open ×3, then 20 closed, then 8 open / 8 closed ×3, then 16 open. `done` after 132 cycles.
- Handshake: `key_valid` high throughout, code changes to 0xA while busy -> the original key completes; 0xA is accepted on the `done` cycle.
- Abort and edge case: reset asserted mid-HOLD -> `row=0` next cycle, IDLE; hold_len=0 -> 1 HOLD cycle.
